seg7_scan_capture: RTL and testbench

//   Reverse path of the BCD/hex-to-7-segment decoder: monitors a time-multiplexed 7-seg bus
//   (segment lines + one-hot digit select) and recovers the hex nibble shown on each digit.
//   A pattern must be stable for STABLE_CYC cycles before it is committed. A frame pulse fires

---
 rtl/seg7_scan_capture.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture
// Brief    : Recovers hex nibbles from a time-multiplexed 7-segment bus with
//            a per-pattern stability filter, frame detection and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     dig_sel_i,
    input  logic                clear_i,
    output logic [4*NDIG-1:0]   value_o,
    output logic [NDIG-1:0]     digit_ok_o,
    output logic                frame_valid_o,
    output logic                pat_err_o,
    output logic                sel_err_o
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);

    logic [6:0]      sample_seg;
    logic [NDIG-1:0] sample_sel;
    logic [7:0]      cnt;
    logic [NDIG-1:0] seen;
    logic [3:0]      val_q [NDIG];

    logic            onehot;
    logic            multihot;
    logic            same;
    logic            commit;
    logic            frame;
    logic [4:0]      dec;

    // Returns {legal, nibble}; legal=0 for any pattern outside the hex font.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h7E: r = 5'h10;
            7'h30: r = 5'h11;
            7'h6D: r = 5'h12;
            7'h79: r = 5'h13;
            7'h33: r = 5'h14;
            7'h5B: r = 5'h15;
            7'h5F: r = 5'h16;
            7'h70: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h7B: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h1F: r = 5'h1B;
            7'h4E: r = 5'h1C;
            7'h3D: r = 5'h1D;
            7'h4F: r = 5'h1E;
            7'h47: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        onehot   = ($countones(dig_sel_i) == 1);
        multihot = ($countones(dig_sel_i) > 1);
        same     = (seg_i == sample_seg) && (dig_sel_i == sample_sel);
        commit   = onehot && same && (cnt == CNT_MAX - 8'd1);
        dec      = decode(seg_i);
        frame    = commit && (&(seen | dig_sel_i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_seg <= '0;
            sample_sel <= '0;
            cnt        <= '0;
        end else if (!onehot) begin
            sample_seg <= seg_i;
            sample_sel <= dig_sel_i;
            cnt        <= '0;
        end else if (same) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            sample_seg <= seg_i;
            sample_sel <= dig_sel_i;
            cnt        <= 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen          <= '0;
            frame_valid_o <= 1'b0;
            pat_err_o     <= 1'b0;
            sel_err_o     <= 1'b0;
            digit_ok_o    <= '0;
            for (int i = 0; i < NDIG; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            frame_valid_o <= frame;

            // A commit in the same cycle as clear still leaves its seen bit set.
            if (frame) begin
                seen <= '0;
            end else if (commit) begin
                seen <= (clear_i ? '0 : seen) | dig_sel_i;
            end else if (clear_i) begin
                seen <= '0;
            end

            if (commit && !dec[4]) begin
                pat_err_o <= 1'b1;
            end else if (clear_i) begin
                pat_err_o <= 1'b0;
            end

            if (multihot) begin
                sel_err_o <= 1'b1;
            end else if (clear_i) begin
                sel_err_o <= 1'b0;
            end

            for (int i = 0; i < NDIG; i++) begin
                if (commit && dig_sel_i[i]) begin
                    digit_ok_o[i] <= dec[4];
                    if (dec[4]) begin
                        val_q[i] <= dec[3:0];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_pack
        assign value_o[4*g +: 4] = val_q[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_capture
// Brief    : Directed and randomized checks of seg7_scan_capture against a
//            run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    localparam int NDIG = 8;
    localparam int ST   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg_i;
    logic [NDIG-1:0]   dig_sel_i;
    logic              clear_i;
    logic [4*NDIG-1:0] value_o;
    logic [NDIG-1:0]   digit_ok_o;
    logic              frame_valid_o;
    logic              pat_err_o;
    logic              sel_err_o;

    seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(ST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_i         (seg_i),
        .dig_sel_i     (dig_sel_i),
        .clear_i       (clear_i),
        .value_o       (value_o),
        .digit_ok_o    (digit_ok_o),
        .frame_valid_o (frame_valid_o),
        .pat_err_o     (pat_err_o),
        .sel_err_o     (sel_err_o)
    );

    always #5 clk = ~clk;

    logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int vectors = 0;
    int fails   = 0;
    int frames  = 0;

    // Reference state: run length of identical one-hot samples.
    int              run;
    logic [6:0]      pseg;
    logic [NDIG-1:0] psel;
    logic [3:0]      m_val [NDIG];
    logic [NDIG-1:0] m_ok;
    logic [NDIG-1:0] m_seen;
    logic            m_frame, m_pat, m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4*NDIG-1:0] ev;
        for (int i = 0; i < NDIG; i++) ev[4*i +: 4] = m_val[i];
        check({tag, ".value"}, 32'(value_o), 32'(ev));
        check({tag, ".ok"},    32'(digit_ok_o), 32'(m_ok));
        check({tag, ".frame"}, 32'(frame_valid_o), 32'(m_frame));
        check({tag, ".pat"},   32'(pat_err_o), 32'(m_pat));
        check({tag, ".sel"},   32'(sel_err_o), 32'(m_sel));
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (codes[k] == s) return k;
        return -1;
    endfunction

    task automatic model_reset();
        run = 0; pseg = '0; psel = '0;
        for (int i = 0; i < NDIG; i++) m_val[i] = '0;
        m_ok = '0; m_seen = '0; m_frame = 0; m_pat = 0; m_sel = 0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [NDIG-1:0] d, input logic c);
        bit oh, com, full;
        int nib;
        oh = ($countones(d) == 1);
        if (!oh) run = 0;
        else if (run > 0 && s == pseg && d == psel) run++;
        else run = 1;
        pseg = s; psel = d;
        com  = oh && (run == ST);
        full = ((m_seen | d) == {NDIG{1'b1}});
        m_frame = com && full;
        if (c) begin m_seen = '0; m_pat = 0; m_sel = 0; end
        if ($countones(d) > 1) m_sel = 1;
        if (com) begin
            nib = lookup(s);
            for (int i = 0; i < NDIG; i++) begin
                if (d[i]) begin
                    if (nib >= 0) begin m_val[i] = 4'(nib); m_ok[i] = 1'b1; end
                    else begin m_ok[i] = 1'b0; m_pat = 1; end
                end
            end
            m_seen = full ? '0 : (m_seen | d);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [NDIG-1:0] d, input logic c, input string tag);
        seg_i = s; dig_sel_i = d; clear_i = c;
        @(posedge clk);
        #1;
        model_edge(s, d, c);
        if (frame_valid_o) frames++;
        check_all(tag);
        clear_i = 1'b0;
    endtask

    task automatic hold(input logic [6:0] s, input logic [NDIG-1:0] d, input int n, input string tag);
        for (int k = 0; k < n; k++) step(s, d, 1'b0, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]      s;
        logic [NDIG-1:0] d;
        int              r;
        rst_n = 1'b0; seg_i = '0; dig_sel_i = '0; clear_i = 1'b0;
        model_reset();
        do_reset();

        // 1: digits 0..7 showing 1..8, one frame at the end
        frames = 0;
        for (int i = 0; i < NDIG; i++) hold(codes[i+1], NDIG'(1) << i, ST, "t1");
        check("t1.value_const", value_o, 32'h87654321);
        check("t1.ok_const", 32'(digit_ok_o), 32'hFF);
        check("t1.frames", frames, 1);

        // 2: three-cycle hold does not commit, a full hold does
        hold(7'h7E, 8'h01, 3, "t2a");
        check("t2.no_commit", 32'(value_o[3:0]), 32'h1);
        hold(7'h6D, 8'h01, ST, "t2b");
        check("t2.commit", 32'(value_o[3:0]), 32'h2);

        // 3: illegal pattern, then clear
        hold(7'h00, 8'h04, ST, "t3");
        check("t3.pat_err", 32'(pat_err_o), 32'h1);
        check("t3.ok2", 32'(digit_ok_o[2]), 32'h0);
        check("t3.val2", 32'(value_o[11:8]), 32'h3);
        step(7'h00, 8'h00, 1'b1, "t3clr");
        check("t3.cleared", 32'(pat_err_o), 32'h0);

        // 4: multi-hot and blank selects
        hold(7'h30, 8'h03, 10, "t4a");
        check("t4.sel_err", 32'(sel_err_o), 32'h1);
        step(7'h00, 8'h00, 1'b1, "t4clr");
        hold(7'h30, 8'h00, 10, "t4b");
        check("t4.blank_sel", 32'(sel_err_o), 32'h0);

        // 5: long hold commits once
        frames = 0;
        hold(7'h4F, 8'h08, 20, "t5");
        check("t5.val3", 32'(value_o[15:12]), 32'hE);
        check("t5.frames", frames, 0);

        // 6: reset in the middle of a hold
        hold(7'h5B, 8'h02, 3, "t6a");
        do_reset();
        hold(7'h5B, 8'h02, 3, "t6b");
        check("t6.no_commit", 32'(value_o[7:4]), 32'h0);
        step(7'h5B, 8'h02, 1'b0, "t6c");
        check("t6.commit", 32'(value_o[7:4]), 32'h5);

        // Randomized holds: mostly legal one-hot, some illegal, blank, multi-hot, clears
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            s = codes[$urandom_range(0, 15)];
            if (r < 2) s = 7'($urandom);
            d = NDIG'(1) << $urandom_range(0, NDIG - 1);
            if (r == 2) d = '0;
            if (r == 3) d = NDIG'($urandom);
            for (int k = 0; k < int'($urandom_range(1, ST + 2)); k++)
                step(s, d, ($urandom_range(0, 29) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
